ifetch_prefetch: RTL and testbench

- Parametrised successor to the single-register fetch stage: a program counter plus a DEPTH-entry prefetch FIFO of {pc, instr} pairs.
- Decouples the instruction memory from decode with a valid/ready handshake.
- Issues word-aligned reads to a synchronous 1-cycle-latency instruction memory, tracking credits so the FIFO never overflows.
- On redirect (jump/branch), the FIFO is flushed and stale in-flight data is discarded.
- Sits between the imem and the IF/ID pipeline register.

---
 rtl/ifetch_prefetch.sv | 143 ++++++++++++++
 tb/tb_ifetch_prefetch.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ifetch_prefetch.sv
// Instruction fetch stage: PC, credit-limited imem requests and a DEPTH-entry {pc, instr} prefetch FIFO.
// Define IFETCH_PERF_EN to add the perf_fetched / perf_flushed / perf_bubble counter ports.
module ifetch_prefetch #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              IMEM_AW  = 9
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               redirect,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [XLEN-1:0]    imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_pc,
  output logic [XLEN-1:0]    out_instr
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_flushed,
  output logic [31:0]        perf_bubble
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_req_pc;
  logic            r_inflight;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_pc_mem    [DEPTH];
  logic [XLEN-1:0] r_instr_mem [DEPTH];

  logic [CW:0]     w_credit;
  logic            w_req;
  logic            w_push;
  logic            w_pop;
  logic [XLEN-1:0] w_target;

  // Slots already promised = buffered entries plus the response still on its way.
  assign w_credit = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
  assign w_req    = reset_n && !redirect && (w_credit < DEPTH_W);
  assign w_push   = r_inflight && !redirect;
  assign w_pop    = out_valid && out_ready && !redirect;
  assign w_target = redirect_pc & ~XLEN'(3);

  assign imem_req  = w_req;
  assign imem_addr = r_fetch_pc[IMEM_AW+1:2];
  assign out_valid = (r_count != '0);
  assign out_pc    = r_pc_mem[r_rd_ptr];
  assign out_instr = r_instr_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_req;
      if (redirect) begin
        r_fetch_pc <= w_target;
      end else if (w_req) begin
        r_fetch_pc <= r_fetch_pc + XLEN'(4);
        r_req_pc   <= r_fetch_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (redirect) begin
      // Flush: the head and every buffered entry are dropped, write pointer stays put.
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_pc_mem[gi]    <= '0;
          r_instr_mem[gi] <= '0;
        end else if (w_push && (r_wr_ptr == PW'(gi))) begin
          r_pc_mem[gi]    <= r_req_pc;
          r_instr_mem[gi] <= imem_rdata;
        end
      end
    end
  endgenerate

`ifdef IFETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_flushed;
  logic [31:0] r_perf_bubble;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_fetched <= '0;
      r_perf_flushed <= '0;
      r_perf_bubble  <= '0;
    end else begin
      if (w_pop) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      if (redirect) begin
        r_perf_flushed <= r_perf_flushed + 32'(r_count) + 32'(r_inflight);
      end
      if (out_ready && !out_valid) begin
        r_perf_bubble <= r_perf_bubble + 32'd1;
      end
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_flushed = r_perf_flushed;
  assign perf_bubble  = r_perf_bubble;
`endif

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Randomized bench for ifetch_prefetch: a queue of outstanding fetches models the credit rule and delivery order.
module tb_ifetch_prefetch;
  localparam int DEPTH = 4;
  localparam int AW    = 9;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_pc;
  logic [31:0]   out_instr;
`ifdef IFETCH_PERF_EN
  logic [31:0]   perf_fetched, perf_flushed, perf_bubble;
  int            m_fetched, m_flushed, m_bubble;
`endif

  ifetch_prefetch #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0), .IMEM_AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr)
`ifdef IFETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed), .perf_bubble(perf_bubble)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] imem [1<<AW];
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= imem[imem_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Outstanding fetches since the last flush, oldest first; age 0 = still in flight.
  logic [31:0] q_pc  [$];
  int          q_age [$];
  logic [31:0] m_fetch_pc;

  function automatic logic [31:0] instr_at(input logic [31:0] pc);
    logic [AW-1:0] a;
    a = pc[AW+1:2];
    return imem[a];
  endfunction

  task automatic model_reset();
    q_pc.delete();
    q_age.delete();
    m_fetch_pc = 32'h0;
`ifdef IFETCH_PERF_EN
    m_fetched = 0; m_flushed = 0; m_bubble = 0;
`endif
  endtask

  // Called at a falling edge: drive, check the cycle, advance the model over the next rising edge.
  task automatic step(input logic rd, input logic rdy, input logic [31:0] tgt);
    logic exp_valid, exp_req;
    redirect = rd;
    redirect_pc = tgt;
    out_ready = rdy;
    #2;
    exp_valid = (q_pc.size() > 0) && (q_age[0] >= 1);
    exp_req   = !rd && (q_pc.size() < DEPTH);
    check_eq("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
    check_eq("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    if (exp_req) check_eq("imem_addr", {23'b0, imem_addr}, {23'b0, m_fetch_pc[AW+1:2]});
    if (exp_valid) begin
      check_eq("out_pc", out_pc, q_pc[0]);
      check_eq("out_instr", out_instr, instr_at(q_pc[0]));
    end
`ifdef IFETCH_PERF_EN
    check_eq("perf_fetched", perf_fetched, 32'(m_fetched));
    check_eq("perf_flushed", perf_flushed, 32'(m_flushed));
    check_eq("perf_bubble", perf_bubble, 32'(m_bubble));
    if (rdy && !exp_valid) m_bubble++;
`endif
    if (rd) begin
`ifdef IFETCH_PERF_EN
      m_flushed += q_pc.size();
`endif
      q_pc.delete();
      q_age.delete();
      m_fetch_pc = tgt & 32'hFFFF_FFFC;
    end else begin
      if (exp_valid && rdy) begin
        void'(q_pc.pop_front());
        void'(q_age.pop_front());
`ifdef IFETCH_PERF_EN
        m_fetched++;
`endif
      end
      for (int i = 0; i < q_age.size(); i++) q_age[i] = q_age[i] + 1;
      if (exp_req) begin
        q_pc.push_back(m_fetch_pc);
        q_age.push_back(0);
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) imem[i] = 32'h100 + i;
    imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #2;
    check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("rst_imem_req", {31'b0, imem_req}, 32'd0);
    check_eq("rst_out_pc", out_pc, 32'd0);
    check_eq("rst_out_instr", out_instr, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Streaming with decode always ready.
    repeat (16) step(1'b0, 1'b1, 32'h0);
    // Decode stalled long enough to fill the FIFO, then drained.
    repeat (10) step(1'b0, 1'b0, 32'h0);
    repeat (8) step(1'b0, 1'b1, 32'h0);
    // Build up a backlog, then redirect to 0x40.
    repeat (3) step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h40);
    repeat (6) step(1'b0, 1'b1, 32'h0);
    // Back-to-back redirects; the second target wins.
    step(1'b1, 1'b1, 32'h80);
    step(1'b1, 1'b1, 32'hC0);
    repeat (6) step(1'b0, 1'b1, 32'h0);
    // Misaligned target and PC wraparound near the top of the address space.
    step(1'b1, 1'b1, 32'hFFFF_FFF3);
    repeat (8) step(1'b0, 1'b1, 32'h0);

    repeat (300) step(($urandom % 16) == 0, ($urandom % 4) != 0, $urandom);

    // Asynchronous reset between edges, mid-burst.
    repeat (4) step(1'b0, 1'b0, 32'h0);
    #6;
    reset_n = 1'b0;
    #1;
    check_eq("async_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("async_imem_req", {31'b0, imem_req}, 32'd0);
    check_eq("async_out_pc", out_pc, 32'd0);
    check_eq("async_out_instr", out_instr, 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) step(1'b0, 1'b1, 32'h0);

    repeat (200) step(($urandom % 12) == 0, ($urandom % 3) != 0, $urandom);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
